// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage of the 5-stage pipeline.
// Holds the ALU opcode encoding, the forwarding-select encoding used by the
// hazard block, and the default datapath / register-address widths.
package execute_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  // ALU operation encoding (alucontrolE)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Forwarding select encoding (forwardAE / forwardBE); 2'b11 is reserved
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   i_a, i_b      : operands (DATA_W)
//   i_alucontrol  : operation select (3 bits, see execute_stage_pkg)
//   o_result      : result, overflow discarded (DATA_W)
//   o_zero        : result == 0
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_alucontrol,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic                     w_lt;
  logic [4:0]               w_shamt;

  assign w_a_s   = i_a;
  assign w_b_s   = i_b;
  assign w_lt    = (w_a_s < w_b_s);
  assign w_shamt = i_b[4:0];

  always_comb begin
    o_result = '0;
    case (i_alucontrol)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_lt};
      ALU_SLL: o_result = i_a << w_shamt;
      ALU_SRL: o_result = i_a >> w_shamt;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute (E) stage of the 5-stage pipeline.
// Selects forwarded ALU operands (register file / W result / M result), runs
// the ALU, resolves beq, computes the branch target, and holds the EX/MEM
// pipeline register.
// Ports:
//   clk, rst (async, active-low), flushE
//   E-stage control: regwriteE, memwriteE, resultsrcE, branchE, alusrcE, alucontrolE
//   E-stage data: rd1E, rd2E, immextE, pcE, pcplus4E, rdE
//   resultW, forwardAE, forwardBE from the W stage / hazard block
//   pcsrcE, pctargetE : combinational branch outputs
//   *M outputs        : EX/MEM register contents
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushE,
  input  logic              regwriteE,
  input  logic              memwriteE,
  input  logic              resultsrcE,
  input  logic              branchE,
  input  logic              alusrcE,
  input  logic [2:0]        alucontrolE,
  input  logic [DATA_W-1:0] rd1E,
  input  logic [DATA_W-1:0] rd2E,
  input  logic [DATA_W-1:0] immextE,
  input  logic [DATA_W-1:0] pcE,
  input  logic [DATA_W-1:0] pcplus4E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [DATA_W-1:0] resultW,
  input  logic [1:0]        forwardAE,
  input  logic [1:0]        forwardBE,
  output logic              pcsrcE,
  output logic [DATA_W-1:0] pctargetE,
  output logic              regwriteM,
  output logic              memwriteM,
  output logic              resultsrcM,
  output logic [REG_AW-1:0] rdM,
  output logic [DATA_W-1:0] aluresultM,
  output logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] pcplus4M
);

  logic [DATA_W-1:0] w_srca;
  logic [DATA_W-1:0] w_fwdb;
  logic [DATA_W-1:0] w_srcb;
  logic [DATA_W-1:0] w_aluresult;
  logic              w_zero;

  logic              r_regwrite_p0;
  logic              r_memwrite_p0;
  logic              r_resultsrc_p0;
  logic [REG_AW-1:0] r_rd_p0;
  logic [DATA_W-1:0] r_aluresult_p0;
  logic [DATA_W-1:0] r_writedata_p0;
  logic [DATA_W-1:0] r_pcplus4_p0;

  // Forwarding muxes; the reserved 2'b11 code falls back to the register file.
  // FWD_M uses the EX/MEM register as held before the edge, i.e. the previous
  // instruction's result.
  always_comb begin
    w_srca = rd1E;
    case (forwardAE)
      FWD_W:   w_srca = resultW;
      FWD_M:   w_srca = r_aluresult_p0;
      default: w_srca = rd1E;
    endcase
  end

  always_comb begin
    w_fwdb = rd2E;
    case (forwardBE)
      FWD_W:   w_fwdb = resultW;
      FWD_M:   w_fwdb = r_aluresult_p0;
      default: w_fwdb = rd2E;
    endcase
  end

  assign w_srcb = alusrcE ? immextE : w_fwdb;

  execute_stage_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_a         (w_srca),
    .i_b         (w_srcb),
    .i_alucontrol(alucontrolE),
    .o_result    (w_aluresult),
    .o_zero      (w_zero)
  );

  // Branch resolution; gated by rst so nothing is redirected while in reset.
  assign pcsrcE    = branchE & w_zero & ~flushE & rst;
  assign pctargetE = pcE + immextE;

  // ---- E -> M boundary (EX/MEM register) ----
  // A flushed slot becomes a bubble: control cleared and rdM=0 so the hazard
  // block never forwards from it. Data fields are loaded regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regwrite_p0  <= 1'b0;
      r_memwrite_p0  <= 1'b0;
      r_resultsrc_p0 <= 1'b0;
      r_rd_p0        <= '0;
      r_aluresult_p0 <= '0;
      r_writedata_p0 <= '0;
      r_pcplus4_p0   <= '0;
    end else begin
      r_regwrite_p0  <= regwriteE  & ~flushE;
      r_memwrite_p0  <= memwriteE  & ~flushE;
      r_resultsrc_p0 <= resultsrcE & ~flushE;
      r_rd_p0        <= flushE ? '0 : rdE;
      r_aluresult_p0 <= w_aluresult;
      r_writedata_p0 <= w_fwdb;
      r_pcplus4_p0   <= pcplus4E;
    end
  end

  assign regwriteM  = r_regwrite_p0;
  assign memwriteM  = r_memwrite_p0;
  assign resultsrcM = r_resultsrc_p0;
  assign rdM        = r_rd_p0;
  assign aluresultM = r_aluresult_p0;
  assign writedataM = r_writedata_p0;
  assign pcplus4M   = r_pcplus4_p0;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        flushE;
  logic        regwriteE;
  logic        memwriteE;
  logic        resultsrcE;
  logic        branchE;
  logic        alusrcE;
  logic [2:0]  alucontrolE;
  logic [31:0] rd1E;
  logic [31:0] rd2E;
  logic [31:0] immextE;
  logic [31:0] pcE;
  logic [31:0] pcplus4E;
  logic [4:0]  rdE;
  logic [31:0] resultW;
  logic [1:0]  forwardAE;
  logic [1:0]  forwardBE;
  logic        pcsrcE;
  logic [31:0] pctargetE;
  logic        regwriteM;
  logic        memwriteM;
  logic        resultsrcM;
  logic [4:0]  rdM;
  logic [31:0] aluresultM;
  logic [31:0] writedataM;
  logic [31:0] pcplus4M;

  int n_vec = 0;
  int n_bad = 0;

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flushE     (flushE),
    .regwriteE  (regwriteE),
    .memwriteE  (memwriteE),
    .resultsrcE (resultsrcE),
    .branchE    (branchE),
    .alusrcE    (alusrcE),
    .alucontrolE(alucontrolE),
    .rd1E       (rd1E),
    .rd2E       (rd2E),
    .immextE    (immextE),
    .pcE        (pcE),
    .pcplus4E   (pcplus4E),
    .rdE        (rdE),
    .resultW    (resultW),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .pcsrcE     (pcsrcE),
    .pctargetE  (pctargetE),
    .regwriteM  (regwriteM),
    .memwriteM  (memwriteM),
    .resultsrcM (resultsrcM),
    .rdM        (rdM),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .pcplus4M   (pcplus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    flushE      = 1'b0;
    regwriteE   = 1'b0;
    memwriteE   = 1'b0;
    resultsrcE  = 1'b0;
    branchE     = 1'b0;
    alusrcE     = 1'b0;
    alucontrolE = 3'b000;
    rd1E        = '0;
    rd2E        = '0;
    immextE     = '0;
    pcE         = '0;
    pcplus4E    = '0;
    rdE         = '0;
    resultW     = '0;
    forwardAE   = 2'b00;
    forwardBE   = 2'b00;
  endtask

  // Inputs change on the falling edge; results are sampled 1 time unit after
  // the rising edge that captures them.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv);
    @(negedge clk);
    idle();
    alucontrolE = op;
    rd1E        = a;
    rd2E        = b;
    edge_sample();
    chk(tag, aluresultM, expv);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    // Branch conditions that would be taken, to show reset gates pcsrcE
    branchE     = 1'b1;
    alucontrolE = 3'b001;
    rd1E        = 32'd9;
    rd2E        = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwriteM", {31'b0, regwriteM}, 32'd0);
    chk("rst_rdM", {27'b0, rdM}, 32'd0);
    chk("rst_aluresultM", aluresultM, 32'd0);
    chk("rst_pcplus4M", pcplus4M, 32'd0);
    chk("rst_pcsrcE", {31'b0, pcsrcE}, 32'd0);

    // Basic sub, first edge after release loads normally
    @(negedge clk);
    rst = 1'b1;
    idle();
    alucontrolE = 3'b001;
    rd1E        = 32'd7;
    rd2E        = 32'd5;
    regwriteE   = 1'b1;
    rdE         = 5'd3;
    pcplus4E    = 32'h44;
    edge_sample();
    chk("sub_aluresultM", aluresultM, 32'd2);
    chk("sub_regwriteM", {31'b0, regwriteM}, 32'd1);
    chk("sub_rdM", {27'b0, rdM}, 32'd3);
    chk("sub_writedataM", writedataM, 32'd5);
    chk("sub_pcplus4M", pcplus4M, 32'h44);

    // ALU operations
    alu_vec("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'd5, 32'd1);
    alu_vec("slt_pos", 3'b101, 32'd5, 32'hFFFF_FFFF, 32'd0);
    alu_vec("and", 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_vec("or", 3'b011, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF);
    alu_vec("xor", 3'b100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
    alu_vec("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1);
    alu_vec("sll31", 3'b110, 32'd1, 32'd31, 32'h8000_0000);
    alu_vec("sll_shamt5", 3'b110, 32'd1, 32'h21, 32'd2);
    alu_vec("srl4", 3'b111, 32'h8000_0000, 32'd4, 32'h0800_0000);

    // M forwarding: load 0x10, then consume it through forwardAE=10
    alu_vec("mfwd_first", 3'b000, 32'h10, 32'd0, 32'h10);
    @(negedge clk);
    idle();
    forwardAE = 2'b10;
    rd1E      = 32'd0;
    rd2E      = 32'd3;
    edge_sample();
    chk("mfwd_aluresultM", aluresultM, 32'h13);

    // Reserved forward code selects the register file
    @(negedge clk);
    idle();
    forwardAE = 2'b11;
    rd1E      = 32'd6;
    rd2E      = 32'd1;
    resultW   = 32'd100;
    edge_sample();
    chk("fwd11_aluresultM", aluresultM, 32'd7);

    // W forwarding on B with immediate operand and store
    @(negedge clk);
    idle();
    rd1E      = 32'h100;
    rd2E      = 32'h5555;
    resultW   = 32'hABCD;
    forwardBE = 2'b01;
    alusrcE   = 1'b1;
    immextE   = 32'd4;
    memwriteE = 1'b1;
    edge_sample();
    chk("wfwd_aluresultM", aluresultM, 32'h104);
    chk("wfwd_writedataM", writedataM, 32'hABCD);
    chk("wfwd_memwriteM", {31'b0, memwriteM}, 32'd1);

    // M forwarding on B into store data
    @(negedge clk);
    idle();
    forwardBE = 2'b10;
    rd2E      = 32'd1;
    rd1E      = 32'd0;
    edge_sample();
    chk("mfwdB_writedataM", writedataM, 32'h104);

    // Branch taken, then squashed by flush
    @(negedge clk);
    idle();
    branchE     = 1'b1;
    alucontrolE = 3'b001;
    rd1E        = 32'd9;
    rd2E        = 32'd9;
    pcE         = 32'h100;
    immextE     = 32'h20;
    #1;
    chk("br_pcsrcE", {31'b0, pcsrcE}, 32'd1);
    chk("br_pctargetE", pctargetE, 32'h120);
    rd2E = 32'd8;
    #1;
    chk("br_nottaken", {31'b0, pcsrcE}, 32'd0);
    rd2E   = 32'd9;
    flushE = 1'b1;
    #1;
    chk("br_flush_pcsrcE", {31'b0, pcsrcE}, 32'd0);
    pcE     = 32'hFFFF_FFF0;
    immextE = 32'h20;
    #1;
    chk("br_target_wrap", pctargetE, 32'h10);

    // Flush bubble
    @(negedge clk);
    idle();
    flushE     = 1'b1;
    regwriteE  = 1'b1;
    memwriteE  = 1'b1;
    resultsrcE = 1'b1;
    rdE        = 5'd5;
    edge_sample();
    chk("flush_regwriteM", {31'b0, regwriteM}, 32'd0);
    chk("flush_memwriteM", {31'b0, memwriteM}, 32'd0);
    chk("flush_resultsrcM", {31'b0, resultsrcM}, 32'd0);
    chk("flush_rdM", {27'b0, rdM}, 32'd0);

    // Reset asserted mid-run clears M outputs without a clock edge
    @(negedge clk);
    idle();
    regwriteE  = 1'b1;
    resultsrcE = 1'b1;
    rdE        = 5'd7;
    rd1E       = 32'd11;
    pcplus4E   = 32'h80;
    edge_sample();
    chk("pre_rst_regwriteM", {31'b0, regwriteM}, 32'd1);
    branchE     = 1'b1;
    alucontrolE = 3'b001;
    rd1E        = 32'd4;
    rd2E        = 32'd4;
    rst         = 1'b0;
    #1;
    chk("async_rst_regwriteM", {31'b0, regwriteM}, 32'd0);
    chk("async_rst_resultsrcM", {31'b0, resultsrcM}, 32'd0);
    chk("async_rst_rdM", {27'b0, rdM}, 32'd0);
    chk("async_rst_pcplus4M", pcplus4M, 32'd0);
    chk("async_rst_pcsrcE", {31'b0, pcsrcE}, 32'd0);

    // Release: first edge loads normally
    @(negedge clk);
    rst = 1'b1;
    idle();
    regwriteE = 1'b1;
    rdE       = 5'd9;
    rd1E      = 32'd20;
    rd2E      = 32'd1;
    edge_sample();
    chk("release_aluresultM", aluresultM, 32'd21);
    chk("release_regwriteM", {31'b0, regwriteM}, 32'd1);
    chk("release_rdM", {27'b0, rdM}, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
